// File: rtl/wb_target_arb_rr.sv
// Per-target round-robin arbiter for the Wishbone NxN interconnect.
// Holds a registered one-hot grant until ack/err, abort or watchdog timeout.
module wb_target_arb_rr #(
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int ID_WIDTH      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic                ack,
    input  logic                err,
    output logic [N_REQ-1:0]    gnt,
    output logic [ID_WIDTH-1:0] gnt_id,
    output logic                active,
    output logic                timeout
);
    localparam int CNT_WIDTH = ($clog2(TIMEOUT_CYCLES + 1) > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_GRANTED, ST_TIMEOUT} state_t;

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [N_REQ-1:0]      gnt_q, gnt_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic [ID_WIDTH:0]     pick_res;
    logic [ID_WIDTH-1:0]   ptr_after;
    logic [N_REQ-1:0]      req_shift;
    logic                  req_cur;
    logic                  release_now;

    // First requester at or after base, wrapping around; {found, index}.
    function automatic logic [ID_WIDTH:0] rr_pick(input logic [N_REQ-1:0] r,
                                                  input logic [ID_WIDTH-1:0] base);
        logic                found;
        logic [ID_WIDTH-1:0] pick;
        logic [N_REQ-1:0]    shifted;
        int                  k;
        found = 1'b0;
        pick  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            k       = (int'(base) + i) % N_REQ;
            shifted = r >> k;
            if (shifted[0]) begin
                found = 1'b1;
                pick  = ID_WIDTH'(k);
            end
        end
        return {found, pick};
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        pick_res    = '0;
        ptr_after   = ID_WIDTH'((int'(id_q) + 1) % N_REQ);
        req_shift   = req >> id_q;
        req_cur     = req_shift[0];
        release_now = ack || err || !req_cur;

        case (state_q)
            ST_IDLE: begin
                pick_res = rr_pick(req, ptr_q);
                if (pick_res[ID_WIDTH]) begin
                    state_d = ST_GRANTED;
                    id_d    = pick_res[ID_WIDTH-1:0];
                    gnt_d   = N_REQ'(1) << pick_res[ID_WIDTH-1:0];
                    cnt_d   = '0;
                end
            end
            ST_GRANTED: begin
                if (release_now) begin
                    // Handoff excludes the releasing initiator so it cannot re-win immediately.
                    ptr_d    = ptr_after;
                    pick_res = rr_pick(req & ~(N_REQ'(1) << id_q), ptr_after);
                    if (pick_res[ID_WIDTH]) begin
                        id_d  = pick_res[ID_WIDTH-1:0];
                        gnt_d = N_REQ'(1) << pick_res[ID_WIDTH-1:0];
                        cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                    end
                end else begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                    if (TIMEOUT_CYCLES > 0 && cnt_q == CNT_LAST) begin
                        state_d = ST_TIMEOUT;
                    end
                end
            end
            ST_TIMEOUT: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                ptr_d   = ptr_after;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        gnt     = gnt_q;
        gnt_id  = id_q;
        active  = |gnt_q;
        timeout = (state_q == ST_TIMEOUT);
    end
endmodule

// File: tb/tb_wb_target_arb_rr.sv
// Self-checking bench for wb_target_arb_rr: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model of the arbitration rules.
module tb_wb_target_arb_rr;
    localparam int N = 4;
    localparam int T = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req   = '0;
    logic       ack   = 1'b0;
    logic       err   = 1'b0;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       active;
    logic       timeout;

    logic [3:0] req_nt = '0;
    logic       ack_nt = 1'b0;
    logic       err_nt = 1'b0;
    logic [3:0] gnt_nt;
    logic [1:0] gnt_id_nt;
    logic       active_nt;
    logic       timeout_nt;

    wb_target_arb_rr #(.N_REQ(N), .TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .reset(reset), .req(req), .ack(ack), .err(err),
        .gnt(gnt), .gnt_id(gnt_id), .active(active), .timeout(timeout)
    );

    wb_target_arb_rr #(.N_REQ(N), .TIMEOUT_CYCLES(0)) dut_nt (
        .clock(clock), .reset(reset), .req(req_nt), .ack(ack_nt), .err(err_nt),
        .gnt(gnt_nt), .gnt_id(gnt_id_nt), .active(active_nt), .timeout(timeout_nt)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: owner (-1 idle), rotation pointer, last granted id, grant age, pulse flag.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_last  = 0;
    int m_age   = 0;
    bit m_to    = 1'b0;
    logic [3:0] prev_gnt = '0;

    function automatic bit bit_of(input logic [3:0] r, input int k);
        logic [3:0] s;
        s = r >> k;
        return s[0];
    endfunction

    function automatic int rr_first(input logic [3:0] r, input int start, input int excl);
        int k;
        for (int i = 0; i < N; i++) begin
            k = (start + i) % N;
            if (bit_of(r, k) && k != excl) return k;
        end
        return -1;
    endfunction

    function automatic logic [7:0] exp_vec();
        logic [3:0] g;
        g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        return {g, 2'(m_last), (m_owner >= 0), m_to};
    endfunction

    task automatic model_step();
        int k;
        if (reset) begin
            m_owner = -1; m_ptr = 0; m_last = 0; m_age = 0; m_to = 1'b0;
        end else if (m_to) begin
            m_owner = -1; m_ptr = (m_last + 1) % N; m_to = 1'b0;
        end else if (m_owner < 0) begin
            k = rr_first(req, m_ptr, -1);
            if (k >= 0) begin
                m_owner = k; m_last = k; m_age = 1;
            end
        end else if (ack || err || !bit_of(req, m_owner)) begin
            m_ptr = (m_owner + 1) % N;
            k = rr_first(req, m_ptr, m_owner);
            m_owner = k;
            if (k >= 0) begin
                m_last = k; m_age = 1;
            end
        end else if (m_age == T) begin
            m_to = 1'b1;
        end else begin
            m_age++;
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        #1;
        if (gnt !== prev_gnt && gnt !== 4'b0000)
            $display("t=%0t grant id=%0d req=%b", $time, gnt_id, req);
        prev_gnt = gnt;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; ack = 1'b0; err = 1'b0; req_nt = '0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 4'hF;
        step(); step(); step();
        checks++;
        if (gnt !== 4'b0000 || active !== 1'b0 || timeout !== 1'b0 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: gnt=%b id=%0d active=%b timeout=%b, required 0000/0/0/0",
                     gnt, gnt_id, active, timeout);
        end
        reset = 1'b0;
        step();
        checks++;
        if (gnt !== 4'b0001 || active !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: gnt=%b active=%b, required 0001/1", gnt, active);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        step();
        checks++;
        if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
            errors++;
            $display("FAIL single_grant: gnt=%b id=%0d, required 0100/2", gnt, gnt_id);
        end
        step(); step();
        ack = 1'b1; req = 4'b0000;
        step();
        ack = 1'b0;
        checks++;
        if (gnt !== 4'b0000 || active !== 1'b0 || gnt_id !== 2'd2) begin
            errors++;
            $display("FAIL single_release: gnt=%b active=%b id=%0d, required 0000/0/2",
                     gnt, active, gnt_id);
        end
        req = 4'b1001;
        step();
        checks++;
        if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
            errors++;
            $display("FAIL single_ptr_next: gnt=%b id=%0d, required 1000/3", gnt, gnt_id);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] want;
        do_reset();
        req = 4'hF;
        step();
        for (int g = 0; g < 5; g++) begin
            want = 4'b0001 << (g % N);
            checks++;
            if (gnt !== want || gnt_id !== 2'(g % N)) begin
                errors++;
                $display("FAIL fairness_order[%0d]: gnt=%b id=%0d, required %b/%0d",
                         g, gnt, gnt_id, want, g % N);
            end
            step();
            checks++;
            if (gnt !== want) begin
                errors++;
                $display("FAIL fairness_hold[%0d]: gnt=%b, required %b", g, gnt, want);
            end
            ack = 1'b1;
            step();
            ack = 1'b0;
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        req = 4'b0010;
        step();
        for (int c = 1; c <= T; c++) begin
            checks++;
            if (gnt !== 4'b0010 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL watchdog_hold[%0d]: gnt=%b timeout=%b, required 0010/0", c, gnt, timeout);
            end
            step();
        end
        checks++;
        if (gnt !== 4'b0010 || timeout !== 1'b1) begin
            errors++;
            $display("FAIL watchdog_pulse: gnt=%b timeout=%b, required 0010/1", gnt, timeout);
        end
        step();
        checks++;
        if (gnt !== 4'b0000 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL watchdog_release: gnt=%b timeout=%b, required 0000/0", gnt, timeout);
        end
        step();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL watchdog_regrant: gnt=%b, required 0010", gnt);
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_watchdog_disabled();
        do_reset();
        req_nt = 4'b0010;
        step();
        for (int c = 1; c <= 40; c++) begin
            checks++;
            if (gnt_nt !== 4'b0010 || timeout_nt !== 1'b0) begin
                errors++;
                $display("FAIL nowatchdog_hold[%0d]: gnt=%b timeout=%b, required 0010/0",
                         c, gnt_nt, timeout_nt);
            end
            step();
        end
        req_nt = 4'b0000;
        step();
        checks++;
        if (gnt_nt !== 4'b0000) begin
            errors++;
            $display("FAIL nowatchdog_abort: gnt=%b, required 0000", gnt_nt);
        end
    endtask

    task automatic test_abort_collision();
        do_reset();
        req = 4'b0010;
        step();
        req = 4'b1010;
        step(); step();
        req = 4'b1000;
        step();
        checks++;
        if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
            errors++;
            $display("FAIL abort_handoff: gnt=%b id=%0d, required 1000/3", gnt, gnt_id);
        end
        for (int c = 2; c <= T; c++) step();
        ack = 1'b1; req = 4'b0000;
        step();
        ack = 1'b0;
        checks++;
        if (gnt !== 4'b0000 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL ack_vs_watchdog: gnt=%b timeout=%b, required 0000/0", gnt, timeout);
        end
        step();
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL ack_vs_watchdog_late: timeout=%b, required 0", timeout);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        req = 4'b0100;
        step(); step();
        reset = 1'b1;
        step();
        checks++;
        if (gnt !== 4'b0000 || timeout !== 1'b0 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset: gnt=%b timeout=%b id=%0d, required 0000/0/0", gnt, timeout, gnt_id);
        end
        reset = 1'b0; req = 4'hF;
        step();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL mid_reset_ptr: gnt=%b, required 0001", gnt);
        end
    endtask

    task automatic test_random();
        logic [7:0] obs;
        logic [7:0] want;
        bit         quiet;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            quiet = ((c / 60) % 3) == 2;
            req   = 4'($urandom_range(0, 15));
            if (m_owner >= 0 && $urandom_range(0, 99) < 85) req = req | (4'b0001 << m_owner);
            ack   = !quiet && ($urandom_range(0, 3) == 0);
            err   = !quiet && ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 199) == 0);
            step();
            obs  = {gnt, gnt_id, active, timeout};
            want = exp_vec();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL random[%0d]: gnt/id/active/timeout=%b/%0d/%b/%b, required %b/%0d/%b/%b",
                         c, obs[7:4], obs[3:2], obs[1], obs[0],
                         want[7:4], want[3:2], want[1], want[0]);
            end
        end
        reset = 1'b0; req = '0; ack = 1'b0; err = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_watchdog();
        test_watchdog_disabled();
        test_abort_collision();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
